// File: rtl/sa3_result_collector.sv
// sa3_result_collector: gathers staggered 3-column PE outputs into a saturated 2x2 result
module sa3_result_collector #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = DATA_W + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] col0_in,
  input  logic [DATA_W-1:0] col1_in,
  input  logic [DATA_W-1:0] col2_in,
  input  logic              out_ready,
  output logic [DATA_W-1:0] c11,
  output logic [DATA_W-1:0] c12,
  output logic [DATA_W-1:0] c21,
  output logic [DATA_W-1:0] c22,
  output logic              out_valid,
  output logic              sat,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  localparam logic [ACC_W-1:0] MAX = ACC_W'((1 << DATA_W) - 1);
  state_t state, state_nx;
  logic [3:0] k, k_nx, kc;
  logic go, cap, fin;
  logic [ACC_W-1:0] a11, a12, a21, a22, n11, n12, n21, n22, z0, z1, z2;
  function automatic logic [DATA_W-1:0] clip(logic [ACC_W-1:0] a);
    return a > MAX ? {DATA_W{1'b1}} : a[DATA_W-1:0];
  endfunction
  // start is honoured from IDLE, or from HOLD when the held result is being accepted
  always_comb begin
    go = start && (state == IDLE || (state == HOLD && out_ready));
    cap = go || state == COLLECT;
    fin = state == COLLECT && k == 4'd9;
    kc = go ? 4'd0 : k;
    state_nx = state;
    k_nx = k;
    if (go) begin
      state_nx = COLLECT;
      k_nx = 4'd1;
    end else if (fin) begin
      state_nx = HOLD;
      k_nx = 4'd0;
    end else if (state == COLLECT) k_nx = k + 4'd1;
    else if (state == HOLD && out_ready) state_nx = IDLE;
  end
  // capture schedule: each column feeds each element once, staggered by the array skew
  always_comb begin
    z0 = ACC_W'(col0_in);
    z1 = ACC_W'(col1_in);
    z2 = ACC_W'(col2_in);
    n11 = (go ? '0 : a11) + (kc == 4'd0 ? z0 : kc == 4'd2 ? z1 : kc == 4'd4 ? z2 : '0);
    n12 = (go ? '0 : a12) + (kc == 4'd1 ? z0 : kc == 4'd3 ? z1 : kc == 4'd5 ? z2 : '0);
    n21 = (go ? '0 : a21) + (kc == 4'd4 ? z0 : kc == 4'd6 ? z1 : kc == 4'd8 ? z2 : '0);
    n22 = (go ? '0 : a22) + (kc == 4'd5 ? z0 : kc == 4'd7 ? z1 : kc == 4'd9 ? z2 : '0);
  end
  // state and capture index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= 4'd0;
    end else begin
      state <= state_nx;
      k <= k_nx;
    end
  end
  // accumulators update on capture cycles; results latch on the final capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {a11, a12, a21, a22} <= '0;
      {c11, c12, c21, c22} <= '0;
      sat <= 1'b0;
    end else begin
      if (cap) begin
        a11 <= n11;
        a12 <= n12;
        a21 <= n21;
        a22 <= n22;
      end
      if (fin) begin
        c11 <= clip(n11);
        c12 <= clip(n12);
        c21 <= clip(n21);
        c22 <= clip(n22);
        sat <= n11 > MAX || n12 > MAX || n21 > MAX || n22 > MAX;
      end
    end
  end
  assign out_valid = state == HOLD;
  assign busy = state == COLLECT;
endmodule

// File: tb/tb_sa3_result_collector.sv
// tb_sa3_result_collector: table-driven scoreboard bench for the 2x2 result collector
module tb_sa3_result_collector;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [7:0] col0_in = '0, col1_in = '0, col2_in = '0;
  logic [7:0] c11, c12, c21, c22;
  logic out_valid, sat, busy;
  int n_chk = 0, n_pass = 0;
  typedef struct {
    logic [7:0] b0, b1, b2, s, e11, e12, e21, e22;
    logic esat;
  } vec_t;
  typedef struct {
    logic [7:0] c11, c12, c21, c22;
    logic sat;
  } res_t;
  res_t sbq[$];
  res_t last;
  vec_t vt[6];

  sa3_result_collector #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .col0_in(col0_in), .col1_in(col1_in), .col2_in(col2_in),
    .out_ready(out_ready),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .out_valid(out_valid), .sat(sat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  function automatic logic [7:0] cv(vec_t v, int n, int k);
    logic [7:0] b;
    b = n == 0 ? v.b0 : n == 1 ? v.b1 : v.b2;
    return 8'(int'(b) + int'(v.s) * k);
  endfunction

  function automatic vec_t model(vec_t v);
    int a11, a12, a21, a22;
    vec_t r;
    r = v;
    a11 = cv(v, 0, 0) + cv(v, 1, 2) + cv(v, 2, 4);
    a12 = cv(v, 0, 1) + cv(v, 1, 3) + cv(v, 2, 5);
    a21 = cv(v, 0, 4) + cv(v, 1, 6) + cv(v, 2, 8);
    a22 = cv(v, 0, 5) + cv(v, 1, 7) + cv(v, 2, 9);
    r.e11 = a11 > 255 ? 8'd255 : 8'(a11);
    r.e12 = a12 > 255 ? 8'd255 : 8'(a12);
    r.e21 = a21 > 255 ? 8'd255 : 8'(a21);
    r.e22 = a22 > 255 ? 8'd255 : 8'(a22);
    r.esat = a11 > 255 || a12 > 255 || a21 > 255 || a22 > 255;
    return r;
  endfunction

  task automatic drive(vec_t v, bit b2b, int n_cyc);
    res_t r;
    r = '{v.e11, v.e12, v.e21, v.e22, v.esat};
    if (n_cyc == 10) sbq.push_back(r);
    for (int i = 0; i < n_cyc; i++) begin
      if (i > 0) begin
        chk("busy_collect", busy, 1);
        chk("valid_collect", out_valid, 0);
      end
      start = i == 0 || (i == 3);
      if (i == 0 && b2b) out_ready = 1'b1;
      else out_ready = 1'($urandom % 2);
      col0_in = cv(v, 0, i);
      col1_in = cv(v, 1, i);
      col2_in = cv(v, 2, i);
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic collect();
    int w;
    res_t r;
    w = 0;
    while (!out_valid && w < 5) begin
      @(negedge clk);
      w++;
    end
    chk("latency_extra_edges", w, 0);
    chk("busy_hold", busy, 0);
    r = sbq.pop_front();
    chk("c11", c11, r.c11);
    chk("c12", c12, r.c12);
    chk("c21", c21, r.c21);
    chk("c22", c22, r.c22);
    chk("sat", sat, r.sat);
    last = r;
  endtask

  task automatic release_hold();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_after_accept", out_valid, 0);
    chk("busy_after_accept", busy, 0);
    chk("c11_kept", c11, last.c11);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    int seen;
    vt[0] = '{1, 1, 1, 0, 3, 3, 3, 3, 0};
    vt[1] = '{1, 16, 32, 1, 55, 58, 67, 70, 0};
    vt[2] = '{200, 200, 200, 0, 255, 255, 255, 255, 1};
    vt[3] = '{85, 85, 85, 0, 255, 255, 255, 255, 0};
    vt[4] = '{10, 20, 30, 2, 72, 78, 96, 102, 0};
    vt[5] = '{0, 0, 240, 1, 246, 249, 255, 255, 1};
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_c", {c11, c12, c21, c22}, 0);
    chk("rst_sat", sat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      drive(vt[j], 0, 10);
      collect();
      release_hold();
    end
    drive(vt[4], 0, 10);
    collect();
    for (int c = 0; c < 5; c++) begin
      start = c == 2;
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_busy", busy, 0);
      chk("bp_c", {c11, c12, c21, c22}, {last.c11, last.c12, last.c21, last.c22});
      chk("bp_sat", sat, last.sat);
    end
    start = 1'b0;
    release_hold();
    @(negedge clk);
    chk("idle_after_bp", busy, 0);
    drive(vt[1], 0, 6);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_c", {c11, c12, c21, c22}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    chk("no_result_after_rst", seen, 0);
    drive(vt[1], 0, 10);
    collect();
    release_hold();
    drive(vt[2], 0, 10);
    collect();
    drive(vt[5], 1, 10);
    collect();
    release_hold();
    for (int j = 0; j < 3; j++) begin
      rv = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 3)), 0, 0, 0, 0, 0};
      drive(model(rv), 0, 10);
      collect();
      release_hold();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
